fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Issue controller that shares one FPU_exu instance between two requesters: port 0 (core decode) and port 1 (host/Wishbone bridge). It arbitrates round-robin and captures the winning request's operands. It sequences the exu's valid/op/operand inputs, waits for completion (fixed latency for fdiv/fsqrt, with a timeout), and returns result, flags and error to the owning port over a valid/ready handshake. It sits between the requesters and FPU_exu, and only one operation is in flight at a time.

## Interface
- DIV_LAT, 24: cycles from issue to result-valid for fdiv/fsqrt (sfpu_op[3], [4]).
- WAIT_LIMIT, 64: max WAIT cycles for other ops before timeout error.
- clk  in  1  clock.
- rst_l  in  1  asynchronous, active-low reset.
- req_valid[p]  in  1 each (p=0,1)  request present.
- req_ready[p]  out  1 each  request accepted this cycle.
- req_op[p]  in  24  one-hot sfpu_op encoding; [23:22] are sign/unsign qualifiers.
- req_rnd[p]  in  3  rounding mode.
- req_fctl[p]  in  4  float_control.
- req_rs1_en[p], req_rs2_en[p]  in  1  GPR operand qualifiers.
- req_a[p], req_b[p], req_c[p]  in  32  operands.
- resp_valid[p]  out  1  response held for port p.
- resp_ready[p]  in  1  response consumed.
- resp_data  out  32  FPR or GPR result.
- resp_is_rd  out  1  result targets an integer register.
- resp_flags  out  5  fflags.
- resp_err  out  1  illegal op or timeout.
- valid_execution, sfpu_op, fpu_rnd, float_control, dec_i0_rs1_en_d, dec_i0_rs2_en_d, gpr_i0_rs1_d, gpr_i0_rs2_d, fs1_data, fs2_data, fs3_data, fpu_sel  out  exu widths  exu drive.
- fpu_result_1, fpu_result_rd, fpu_complete, fpu_complete_rd, sflags  in  exu widths  exu return.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the requesting port; if both request, grant goes to the port not served last. A `last` register resets to 1, so port 0 wins the first tie.
  - req_ready[g] = 1 only in IDLE for the granted valid port, combinational from req_valid.
  - On accept, op, rnd, fctl, enables and operands are captured into holding registers and the owner is recorded.
  - Illegal op: popcount(req_op[21:0]) != 1. The request is still accepted, but the block goes directly to RESP with resp_err=1, resp_data=0 and resp_flags=0; nothing is issued.
  - Legal op goes to ISSUE.
- ISSUE (1 cycle):
  - valid_execution=1 and fpu_sel=3'b001; sfpu_op and the operands come from the holding registers.
  - Counter loads DIV_LAT-1 if op[3]|op[4], else WAIT_LIMIT-1.
  - Next state: WAIT.
- WAIT:
  - valid_execution=0; sfpu_op, operands and fpu_rnd stay held.
  - Non-div/sqrt ops: when fpu_complete=1, latch result and flags, then go to RESP.
    - resp_is_rd = fpu_complete_rd.
    - resp_data = fpu_result_rd if is_rd, else fpu_result_1.
    - resp_flags = sflags, taken the cycle after fpu_complete, because sflags is registered inside the exu. WAIT therefore holds one extra cycle after fpu_complete before going to RESP.
  - Div/sqrt ops: when the counter reaches 0, latch fpu_result_1 and sflags, set resp_is_rd=0, go to RESP.
  - Counter reaches 0 with no fpu_complete (non-div op): resp_err=1, resp_data=0, go to RESP.
- RESP:
  - resp_valid[owner]=1 and stays stable until resp_ready[owner].
  - On the handshake: clear resp_valid, flip `last` to owner, go to IDLE.
  - A new request cannot be accepted in the same cycle as the handshake.
- Reset (async, any state): state=IDLE, counter=0, all holding registers 0, last=1. Any in-flight op is dropped and never reported; requesters reissue.
- Reset values: every output 0, including req_ready, resp_valid, valid_execution and fpu_sel.

## Timing
- Single-cycle op, no backpressure:
  - accept at edge 0, ISSUE in cycle 1, fpu_complete in cycle 2, flag capture in cycle 3, resp_valid from cycle 4.
  - Accept-to-response latency is 4 cycles.
- fdiv/fsqrt: resp_valid DIV_LAT+2 cycles after accept.
- Throughput: at most one op per 5 cycles.
- fpu_complete in ISSUE, or in RESP, is ignored.
- Simultaneous resp_ready and new req_valid: the response completes and the request waits one cycle.

## Structure
- Shared package fpu_pkg holds:
  - state enum;
  - SFPU_OP_W=24;
  - bit-index constants (OP_FDIV=3, OP_FSQRT=4, OP_FCLASS=21, ...);
  - function is_multicycle(op).
- One sub-module: fpu_rr_arb2, a 2-requester round-robin arbiter with a `last` register and an advance input.
- Everything else lives in fpu_issue_ctrl.

## Test plan
- Port 0 fadd (op=24'h000001, a=32'h3F800000, b=32'h40000000); exu model returns 32'h40400000 with flags 0 -> resp_valid[0] 4 cycles after accept, data 32'h40400000, is_rd=0, err=0.
- Both ports request feq the same cycle; first tie and next tie -> grants go port 0, then port 1, alternating; port 1's req_ready stays 0 until port 0's response is consumed.
- fdiv with DIV_LAT=24 -> valid_execution pulses exactly once; resp_valid 26 cycles after accept; data equals fpu_result_1 sampled at counter 0.
- req_op=24'h000003 (two hot bits) -> accepted; resp_err=1 one cycle later; valid_execution never asserts.
- fadd with the model never raising fpu_complete, WAIT_LIMIT=64 -> resp_err=1, data 0, after 64 WAIT cycles.
- rst_l dropped in WAIT, and again in RESP with resp_ready=0 -> all outputs 0 immediately; after release the next request is served normally, with port 0 winning ties.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the FPU issue controller and its arbiter.
//   fpu_state_e   - issue controller states.
//   fpu_req_t     - one captured request (op, rounding, control, enables, operands).
//   OP_* indices  - bit positions inside the one-hot sfpu_op vector.
//   is_multicycle - op is one of the fixed-latency fdiv/fsqrt operations.
//   is_legal_op   - exactly one op bit set in the one-hot part of the vector.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fpu_state_e;

  localparam int SFPU_OP_W      = 24;
  localparam int OP_FADD        = 0;
  localparam int OP_FDIV        = 3;
  localparam int OP_FSQRT       = 4;
  localparam int OP_FCLASS      = 21;
  // Bits above this index are sign/unsign qualifiers, not operations.
  localparam int OP_ONEHOT_W    = 22;

  localparam int DEF_DIV_LAT    = 24;
  localparam int DEF_WAIT_LIMIT = 64;

  localparam logic [2:0] FPU_SEL_SFPU = 3'b001;

  typedef struct packed {
    logic [SFPU_OP_W-1:0] op;
    logic [2:0]           rnd;
    logic [3:0]           fctl;
    logic                 rs1_en;
    logic                 rs2_en;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          c;
  } fpu_req_t;

  function automatic logic is_multicycle(input logic [SFPU_OP_W-1:0] op);
    return op[OP_FDIV] | op[OP_FSQRT];
  endfunction

  function automatic logic is_legal_op(input logic [SFPU_OP_W-1:0] op);
    return $countones(op[OP_ONEHOT_W-1:0]) == 1;
  endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// fpu_rr_arb2: two-requester round-robin arbiter.
//   clk, rst_l - clock, asynchronous active-low reset.
//   req[1:0]   - request vector.
//   advance    - a service by 'owner' has completed; remember it as last.
//   owner      - port whose service completed.
//   gnt[1:0]   - one-hot grant (zero when nobody requests).
// On a tie the port that was not served last wins. last resets to 1 so
// port 0 wins the first tie.
module fpu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] gnt
);

  logic last_reg;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_reg <= 1'b1;
    end else if (advance) begin
      last_reg <= owner;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_reg ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: shares one FPU_exu between two requesters (0: core
// decode, 1: host bridge). One operation is in flight at a time.
//   clk, rst_l            - clock, asynchronous active-low reset.
//   req_*[p]              - request channel of port p (valid/ready, op, operands).
//   resp_valid/ready[p]   - response handshake of port p.
//   resp_data/is_rd/flags/err - response payload, shared by both ports.
//   valid_execution ... fpu_sel - drive into the exu.
//   fpu_result_1 ... sflags     - return from the exu.
// Flow: IDLE accepts and captures, ISSUE pulses valid_execution, WAIT
// collects the result (fixed latency for fdiv/fsqrt, completion-with-timeout
// otherwise), RESP holds the response until the owner takes it.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DIV_LAT    = DEF_DIV_LAT,
  parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][SFPU_OP_W-1:0]  req_op,
  input  logic [1:0][2:0]            req_rnd,
  input  logic [1:0][3:0]            req_fctl,
  input  logic [1:0]                 req_rs1_en,
  input  logic [1:0]                 req_rs2_en,
  input  logic [1:0][31:0]           req_a,
  input  logic [1:0][31:0]           req_b,
  input  logic [1:0][31:0]           req_c,
  output logic [1:0]                 resp_valid,
  input  logic [1:0]                 resp_ready,
  output logic [31:0]                resp_data,
  output logic                       resp_is_rd,
  output logic [4:0]                 resp_flags,
  output logic                       resp_err,
  output logic                       valid_execution,
  output logic [SFPU_OP_W-1:0]       sfpu_op,
  output logic [2:0]                 fpu_rnd,
  output logic [3:0]                 float_control,
  output logic                       dec_i0_rs1_en_d,
  output logic                       dec_i0_rs2_en_d,
  output logic [31:0]                gpr_i0_rs1_d,
  output logic [31:0]                gpr_i0_rs2_d,
  output logic [31:0]                fs1_data,
  output logic [31:0]                fs2_data,
  output logic [31:0]                fs3_data,
  output logic [2:0]                 fpu_sel,
  input  logic [31:0]                fpu_result_1,
  input  logic [31:0]                fpu_result_rd,
  input  logic                       fpu_complete,
  input  logic                       fpu_complete_rd,
  input  logic [4:0]                 sflags
);

  localparam int CNT_MAX = (DIV_LAT > WAIT_LIMIT) ? DIV_LAT : WAIT_LIMIT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  fpu_state_e state_reg, state_next;
  fpu_req_t   hold_reg;
  fpu_req_t   port_req [2];
  logic [CNT_W-1:0] cnt_reg;
  logic       owner_reg;
  logic       flag_wait_reg;   // completion seen, sflags arrive next cycle
  logic [31:0] resp_data_reg;
  logic       resp_is_rd_reg;
  logic [4:0] resp_flags_reg;
  logic       resp_err_reg;

  logic [1:0] gnt;
  logic       grant_port;
  fpu_req_t   sel_req;
  logic       accept;
  logic       sel_legal;
  logic       hold_multi;
  logic       cnt_zero;
  logic       resp_hs;

  // Gather each port's request fields into one record.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign port_req[gi].op     = req_op[gi];
      assign port_req[gi].rnd    = req_rnd[gi];
      assign port_req[gi].fctl   = req_fctl[gi];
      assign port_req[gi].rs1_en = req_rs1_en[gi];
      assign port_req[gi].rs2_en = req_rs2_en[gi];
      assign port_req[gi].a      = req_a[gi];
      assign port_req[gi].b      = req_b[gi];
      assign port_req[gi].c      = req_c[gi];
    end
  endgenerate

  fpu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_l   (rst_l),
    .req     (req_valid),
    .advance (resp_hs),
    .owner   (owner_reg),
    .gnt     (gnt)
  );

  assign grant_port = gnt[1];
  assign sel_req    = port_req[grant_port];
  assign accept     = (state_reg == ST_IDLE) && (gnt != 2'b00);
  assign sel_legal  = is_legal_op(sel_req.op);
  assign hold_multi = is_multicycle(hold_reg.op);
  assign cnt_zero   = (cnt_reg == '0);
  assign resp_hs    = (state_reg == ST_RESP) && resp_ready[owner_reg];

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = sel_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (hold_multi) begin
          if (cnt_zero) state_next = ST_RESP;
        end else if (flag_wait_reg) begin
          state_next = ST_RESP;
        end else if (!fpu_complete && cnt_zero) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_hs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state. req_ready is combinational from req_valid,
  // so it is also qualified by rst_l to stay low while reset is held.
  always_comb begin
    valid_execution = 1'b0;
    fpu_sel         = 3'b000;
    req_ready       = 2'b00;
    resp_valid      = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        if (rst_l) req_ready = gnt;
      end
      ST_ISSUE: begin
        valid_execution = 1'b1;
        fpu_sel         = FPU_SEL_SFPU;
      end
      ST_RESP: begin
        resp_valid[0] = ~owner_reg;
        resp_valid[1] = owner_reg;
      end
      default: ;
    endcase
  end

  // Holding registers, counter and response capture
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hold_reg       <= '0;
      cnt_reg        <= '0;
      owner_reg      <= 1'b0;
      flag_wait_reg  <= 1'b0;
      resp_data_reg  <= '0;
      resp_is_rd_reg <= 1'b0;
      resp_flags_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            hold_reg      <= sel_req;
            owner_reg     <= grant_port;
            flag_wait_reg <= 1'b0;
            if (!sel_legal) begin
              resp_err_reg   <= 1'b1;
              resp_data_reg  <= '0;
              resp_flags_reg <= '0;
              resp_is_rd_reg <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          cnt_reg <= hold_multi ? CNT_W'(DIV_LAT - 1) : CNT_W'(WAIT_LIMIT - 1);
        end
        ST_WAIT: begin
          if (hold_multi) begin
            // Fixed latency: the exu result is valid when the count expires.
            if (cnt_zero) begin
              resp_data_reg  <= fpu_result_1;
              resp_flags_reg <= sflags;
              resp_is_rd_reg <= 1'b0;
              resp_err_reg   <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end else if (flag_wait_reg) begin
            // sflags is registered inside the exu, one cycle behind complete.
            resp_flags_reg <= sflags;
            flag_wait_reg  <= 1'b0;
          end else if (fpu_complete) begin
            resp_is_rd_reg <= fpu_complete_rd;
            resp_data_reg  <= fpu_complete_rd ? fpu_result_rd : fpu_result_1;
            resp_err_reg   <= 1'b0;
            flag_wait_reg  <= 1'b1;
          end else if (cnt_zero) begin
            resp_err_reg   <= 1'b1;
            resp_data_reg  <= '0;
            resp_flags_reg <= '0;
            resp_is_rd_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data       = resp_data_reg;
  assign resp_is_rd      = resp_is_rd_reg;
  assign resp_flags      = resp_flags_reg;
  assign resp_err        = resp_err_reg;
  assign sfpu_op         = hold_reg.op;
  assign fpu_rnd         = hold_reg.rnd;
  assign float_control   = hold_reg.fctl;
  assign dec_i0_rs1_en_d = hold_reg.rs1_en;
  assign dec_i0_rs2_en_d = hold_reg.rs2_en;
  assign gpr_i0_rs1_d    = hold_reg.a;
  assign gpr_i0_rs2_d    = hold_reg.b;
  assign fs1_data        = hold_reg.a;
  assign fs2_data        = hold_reg.b;
  assign fs3_data        = hold_reg.c;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: table-driven single-request vectors,
// hand-written arbitration/reset sequences, and a randomized phase checked
// against a transaction-level timing model.
module tb_fpu_issue_ctrl;
  localparam int DIV_LAT    = 24;
  localparam int WAIT_LIMIT = 64;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic [1:0] req_valid, req_ready, req_rs1_en, req_rs2_en, resp_valid, resp_ready;
  logic [1:0][23:0] req_op;
  logic [1:0][2:0]  req_rnd;
  logic [1:0][3:0]  req_fctl;
  logic [1:0][31:0] req_a, req_b, req_c;
  logic [31:0] resp_data;
  logic        resp_is_rd, resp_err;
  logic [4:0]  resp_flags;
  logic        valid_execution, dec_i0_rs1_en_d, dec_i0_rs2_en_d;
  logic [23:0] sfpu_op;
  logic [2:0]  fpu_rnd, fpu_sel;
  logic [3:0]  float_control;
  logic [31:0] gpr_i0_rs1_d, gpr_i0_rs2_d, fs1_data, fs2_data, fs3_data;
  logic [31:0] fpu_result_1, fpu_result_rd;
  logic        fpu_complete, fpu_complete_rd;
  logic [4:0]  sflags;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.DIV_LAT(DIV_LAT), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rnd(req_rnd),
    .req_fctl(req_fctl), .req_rs1_en(req_rs1_en), .req_rs2_en(req_rs2_en),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_is_rd(resp_is_rd), .resp_flags(resp_flags), .resp_err(resp_err),
    .valid_execution(valid_execution), .sfpu_op(sfpu_op), .fpu_rnd(fpu_rnd),
    .float_control(float_control), .dec_i0_rs1_en_d(dec_i0_rs1_en_d),
    .dec_i0_rs2_en_d(dec_i0_rs2_en_d), .gpr_i0_rs1_d(gpr_i0_rs1_d),
    .gpr_i0_rs2_d(gpr_i0_rs2_d), .fs1_data(fs1_data), .fs2_data(fs2_data),
    .fs3_data(fs3_data), .fpu_sel(fpu_sel),
    .fpu_result_1(fpu_result_1), .fpu_result_rd(fpu_result_rd),
    .fpu_complete(fpu_complete), .fpu_complete_rd(fpu_complete_rd), .sflags(sflags)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic any_out();
    return |{req_ready, resp_valid, resp_data, resp_is_rd, resp_flags, resp_err,
             valid_execution, sfpu_op, fpu_rnd, float_control, dec_i0_rs1_en_d,
             dec_i0_rs2_en_d, gpr_i0_rs1_d, gpr_i0_rs2_d, fs1_data, fs2_data,
             fs3_data, fpu_sel};
  endfunction

  // ---------------- exu behavioural model ----------------
  // mode 0: single-cycle op completes the cycle after issue, flags one cycle
  // later; mode 1: never completes. fdiv/fsqrt result appears DIV_LAT cycles
  // after issue. Outside those cycles the result buses carry junk.
  int          exu_mode = 0;
  logic [31:0] exu_res = '0;
  logic        exu_rd = 1'b0;
  logic [4:0]  exu_flags = '0;

  initial begin
    bit m_active = 0;
    bit m_div = 0;
    int m_age = 0;
    fpu_complete = 0; fpu_complete_rd = 0; sflags = 0;
    fpu_result_1 = 0; fpu_result_rd = 0;
    forever begin
      @(posedge clk); #1;
      fpu_complete = 0; fpu_complete_rd = 0; sflags = 0;
      fpu_result_1 = 32'hDEADBEEF; fpu_result_rd = 32'hBAADF00D;
      if (!rst_l) m_active = 0;
      else if (valid_execution) begin
        m_active = 1; m_age = 0; m_div = sfpu_op[3] | sfpu_op[4];
      end else if (m_active) begin
        m_age++;
        if (!m_div && exu_mode == 0 && m_age == 1) begin
          fpu_complete = 1; fpu_complete_rd = exu_rd;
          if (exu_rd) fpu_result_rd = exu_res; else fpu_result_1 = exu_res;
        end
        if (!m_div && exu_mode == 0 && m_age == 2) begin
          sflags = exu_flags; m_active = 0;
        end
        if (m_div && m_age == DIV_LAT) begin
          fpu_result_1 = exu_res; sflags = exu_flags; m_active = 0;
        end
      end
    end
  end

  task automatic set_req(input int p, input logic [23:0] op, input logic [31:0] a);
    req_op[p] = op; req_a[p] = a; req_b[p] = ~a; req_c[p] = a ^ 32'h5A5A5A5A;
    req_rnd[p] = 3'($urandom_range(0, 7)); req_fctl[p] = 4'($urandom_range(0, 15));
    req_rs1_en[p] = 1'($urandom_range(0, 1)); req_rs2_en[p] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_l = 0; req_valid = 0; resp_ready = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_l = 1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int          port;
    logic [23:0] op;
    logic [31:0] a;
    logic [31:0] res;
    logic [4:0]  flags;
    logic        is_rd;
    int          mode;
    int          exp_lat;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [4:0]  exp_flags;
    logic        exp_rd;
    int          exp_vex;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0;
    int vex = 0;
    bit got = 0;
    logic [1:0] pmask;
    pmask = 2'(1 << v.port);
    exu_mode = v.mode; exu_res = v.res; exu_rd = v.is_rd; exu_flags = v.flags;
    @(posedge clk); #1;
    set_req(v.port, v.op, v.a);
    req_valid = pmask; resp_ready = 0;
    @(negedge clk);
    check($sformatf("v%0d_accept", idx), req_ready, pmask);
    @(posedge clk); #1;
    req_valid = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (valid_execution) vex++;
      if (resp_valid != 2'b00) got = 1;
    end
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_resp_valid", idx), resp_valid, pmask);
    check($sformatf("v%0d_payload", idx), {resp_data, resp_err, resp_flags, resp_is_rd},
          {v.exp_data, v.exp_err, v.exp_flags, v.exp_rd});
    check($sformatf("v%0d_vex_count", idx), vex, v.exp_vex);
    $display("vec %0d port=%0d op=%h lat=%0d data=%h err=%0d flags=%h rd=%0d",
             idx, v.port, v.op, lat, resp_data, resp_err, resp_flags, resp_is_rd);
    repeat (2) begin
      @(negedge clk);
      check($sformatf("v%0d_hold", idx), {resp_valid, resp_data}, {pmask, v.exp_data});
    end
    @(posedge clk); #1; resp_ready = 2'b11;
    @(posedge clk); #1; resp_ready = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d_resp_clear", idx), resp_valid, 2'b00);
  endtask

  // ---------------- random phase model state ----------------
  bit          pend[2];
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_resp_at = 0;
  int          m_vex_at = -1;
  bit          m_last = 1;
  logic [31:0] e_data;
  logic        e_err, e_rd;
  logic [4:0]  e_flags;

  initial begin
    req_valid = 0; resp_ready = 0;
    req_op = '0; req_rnd = '0; req_fctl = '0; req_rs1_en = 0; req_rs2_en = 0;
    req_a = '0; req_b = '0; req_c = '0;

    //        port op          a             res           flg   rd mode lat data          err flags rd vex
    vecs[0] = '{0, 24'h000001, 32'h3F800000, 32'h40400000, 5'h00, 0, 0, 4,  32'h40400000, 0, 5'h00, 0, 1};
    vecs[1] = '{1, 24'h000004, 32'h11111111, 32'h12345678, 5'h01, 0, 0, 4,  32'h12345678, 0, 5'h01, 0, 1};
    vecs[2] = '{0, 24'hA00000, 32'h7FC00000, 32'h00000200, 5'h00, 1, 0, 4,  32'h00000200, 0, 5'h00, 1, 1};
    vecs[3] = '{1, 24'h000008, 32'h3F800000, 32'h3F000000, 5'h08, 1, 0, 26, 32'h3F000000, 0, 5'h08, 0, 1};
    vecs[4] = '{0, 24'h400010, 32'h40000000, 32'h3FB504F3, 5'h01, 0, 0, 26, 32'h3FB504F3, 0, 5'h01, 0, 1};
    vecs[5] = '{1, 24'h000003, 32'h01234567, 32'h55555555, 5'h1F, 0, 0, 1,  32'h00000000, 1, 5'h00, 0, 0};
    vecs[6] = '{0, 24'hC00000, 32'h89ABCDEF, 32'h55555555, 5'h1F, 0, 0, 1,  32'h00000000, 1, 5'h00, 0, 0};
    vecs[7] = '{0, 24'h000001, 32'h3F800000, 32'h40400000, 5'h04, 0, 1, 66, 32'h00000000, 1, 5'h00, 0, 1};
    vecs[8] = '{1, 24'h000400, 32'h3F800000, 32'h00000001, 5'h10, 1, 0, 4,  32'h00000001, 0, 5'h10, 1, 1};

    // reset state
    @(negedge clk);
    check("reset_outputs_low", any_out(), 1'b0);
    @(posedge clk); #1; rst_l = 1;
    @(negedge clk);
    check("post_reset_outputs", any_out(), 1'b0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // ---- tie arbitration and handshake blocking ----
    do_reset();
    exu_mode = 0; exu_res = 32'h00000001; exu_rd = 1; exu_flags = 0;
    set_req(0, 24'h000400, 32'h1); set_req(1, 24'h000400, 32'h2);
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      req_valid = (c <= 11) ? 2'b11 : 2'b00;
      resp_ready = (c == 5) ? 2'b01 : (c == 10) ? 2'b10 : (c == 15) ? 2'b01 : 2'b00;
      @(negedge clk);
      case (c)
        0:          check("tie_first_port0", req_ready, 2'b01);
        1, 2, 3:    check("busy_blocks_port1", req_ready, 2'b00);
        4:          check("tie_resp_port0", resp_valid, 2'b01);
        5:          check("hs_blocks_request", {req_ready, resp_valid}, {2'b00, 2'b01});
        6:          check("tie_second_port1", req_ready, 2'b10);
        7, 8, 9:    check("busy_blocks_port0", req_ready, 2'b00);
        10:         check("tie_resp_port1", {resp_valid, resp_data}, {2'b10, 32'h1});
        11:         check("tie_third_port0", req_ready, 2'b01);
        15:         check("tie_resp3_port0", resp_valid, 2'b01);
        16:         check("tie_drained", resp_valid, 2'b00);
        default: ;
      endcase
      if (c == 0 || c == 6 || c == 11) $display("tie cycle %0d grant=%b", c, req_ready);
    end

    // ---- reset while in WAIT ----
    do_reset();
    exu_mode = 0; exu_res = 32'h3F000000; exu_rd = 0; exu_flags = 5'h02;
    @(posedge clk); #1;
    set_req(1, 24'h000008, 32'h40800000); req_valid = 2'b10;
    @(negedge clk);
    check("rw_accept", req_ready, 2'b10);
    @(posedge clk); #1; req_valid = 0;
    repeat (5) @(posedge clk);
    #3;
    check("wait_holds_op", sfpu_op, 24'h000008);
    rst_l = 0; #1;
    check("reset_in_wait", any_out(), 1'b0);
    $display("reset asserted during WAIT");
    @(posedge clk); @(posedge clk); #1; rst_l = 1;

    // ---- reset while in RESP with resp_ready low ----
    @(posedge clk); #1;
    set_req(0, 24'h000003, 32'h1); req_valid = 2'b01;
    @(negedge clk);
    check("illegal_accept", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = 0;
    #2;
    check("illegal_resp_next", {resp_valid, resp_err, valid_execution}, {2'b01, 1'b1, 1'b0});
    rst_l = 0; #1;
    check("reset_in_resp", any_out(), 1'b0);
    $display("reset asserted during RESP");
    @(posedge clk); @(posedge clk); #1; rst_l = 1;

    // ---- service after reset, port 0 wins the tie ----
    exu_mode = 0; exu_res = 32'h40A00000; exu_rd = 0; exu_flags = 5'h01;
    @(posedge clk); #1;
    set_req(0, 24'h000001, 32'h40000000); set_req(1, 24'h000001, 32'h3F800000);
    req_valid = 2'b11;
    @(negedge clk);
    check("post_reset_tie", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_reset_resp", {resp_valid, resp_data, resp_flags, resp_err},
          {2'b01, 32'h40A00000, 5'h01, 1'b0});
    $display("post-reset txn data=%h flags=%h", resp_data, resp_flags);
    @(posedge clk); #1; resp_ready = 2'b01;
    @(posedge clk); #1; resp_ready = 2'b00;

    // ---- randomized phase ----
    do_reset();
    pend[0] = 0; pend[1] = 0;
    m_busy = 0; m_last = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [1:0] exp_ready, exp_rv;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          int kind, b1, b2;
          logic [21:0] body;
          logic [23:0] op;
          kind = $urandom_range(0, 19);
          b1 = $urandom_range(0, 21);
          if (kind < 4) b1 = 3 + (kind % 2);
          body = 22'(1) << b1;
          if (kind == 19) begin
            b2 = (b1 + 1 + $urandom_range(0, 20)) % 22;
            body = body | (22'(1) << b2);
          end else if (kind == 18) begin
            body = '0;
          end
          op = {2'($urandom_range(0, 3)), body};
          set_req(p, op, $urandom);
          pend[p] = 1;
        end
        req_valid[p] = pend[p];
      end
      resp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);

      exp_ready = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
        else exp_ready = req_valid;
      end
      exp_rv = (m_busy && cyc >= m_resp_at) ? 2'(1 << m_owner) : 2'b00;
      check("rand_req_ready", req_ready, exp_ready);
      check("rand_resp_valid", resp_valid, exp_rv);
      check("rand_vex", valid_execution, (m_busy && cyc == m_vex_at));
      if (exp_rv != 2'b00)
        check("rand_payload", {resp_data, resp_err, resp_flags, resp_is_rd},
              {e_data, e_err, e_flags, e_rd});

      if (exp_rv != 2'b00 && resp_ready[m_owner]) begin
        $display("rand txn port=%0d data=%h err=%0d flags=%h rd=%0d",
                 m_owner, resp_data, resp_err, resp_flags, resp_is_rd);
        m_busy = 0;
        m_last = (m_owner == 1);
      end else if (exp_ready != 2'b00) begin
        int g;
        logic [23:0] op;
        g = exp_ready[1] ? 1 : 0;
        op = req_op[g];
        pend[g] = 0;
        m_busy = 1; m_owner = g; m_vex_at = cyc + 1;
        exu_res = $urandom; exu_flags = 5'($urandom_range(0, 31));
        exu_rd = 1'($urandom_range(0, 1));
        exu_mode = 0;
        if ($countones(op[21:0]) != 1) begin
          m_resp_at = cyc + 1; m_vex_at = -1;
          e_data = 0; e_err = 1; e_flags = 0; e_rd = 0;
        end else if (op[3] || op[4]) begin
          m_resp_at = cyc + DIV_LAT + 2;
          e_data = exu_res; e_err = 0; e_flags = exu_flags; e_rd = 0;
        end else if ($urandom_range(0, 9) == 0) begin
          exu_mode = 1;
          m_resp_at = cyc + WAIT_LIMIT + 2;
          e_data = 0; e_err = 1; e_flags = 0; e_rd = 0;
        end else begin
          m_resp_at = cyc + 4;
          e_data = exu_res; e_err = 0; e_flags = exu_flags; e_rd = exu_rd;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
